// File: rtl/gaussian_filter_param_if.sv
// Pixel stream bundle for the 3x3 filter: raster input beats in, filtered beats out.
interface gaussian_filter_param_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] iGray;
    logic              iDVAL;
    logic              iSOF;
    logic [1:0]        iMode;
    logic [DATA_W-1:0] oPixel;
    logic              oDVAL;
    logic              oEOF;

    modport master (
        output iGray, iDVAL, iSOF, iMode,
        input  oPixel, oDVAL, oEOF
    );

    modport slave (
        input  iGray, iDVAL, iSOF, iMode,
        output oPixel, oDVAL, oEOF
    );
endinterface

// File: rtl/gaussian_filter_param.sv
// Streaming 3x3 filter (bypass / Gaussian / Laplacian magnitude) with frame tracking,
// valid-gated window and defined border output; one output beat per input beat.
module gaussian_filter_param #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    gaussian_filter_param_if.slave  bus
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int GW = DATA_W + 4;
    localparam int LW = DATA_W + 5;
    localparam int NW = DATA_W + 3;

    logic [XW-1:0] xReg, xNext, curX;
    logic [YW-1:0] yReg, yNext, curY;
    logic [1:0]    modeReg;
    logic [DATA_W-1:0] pixelReg, pixelNext;
    logic          dvalReg, eofReg;
    logic          isOrigin, isLast;

    logic [DATA_W-1:0] line1Mem [0:IMG_W-1];
    logic [DATA_W-1:0] line2Mem [0:IMG_W-1];
    logic [DATA_W-1:0] line1Rd, line2Rd;
    logic [DATA_W-1:0] colIn [3];
    logic [DATA_W-1:0] win [3][3];

    logic [GW-1:0]        gaussSum;
    logic [NW-1:0]        neighSum;
    logic signed [LW-1:0] lapVal;
    logic [LW-1:0]        lapAbs;
    logic [DATA_W-1:0]    center, gaussOut, lapSat, modeResult;

    // An iSOF beat is pixel (0,0) no matter where the counters stand.
    always_comb begin
        isOrigin = bus.iDVAL & bus.iSOF;
        curX     = isOrigin ? '0 : xReg;
        curY     = isOrigin ? '0 : yReg;
        isLast   = (curX == XW'(IMG_W - 1)) && (curY == YW'(IMG_H - 1));
        xNext    = curX + 1'b1;
        yNext    = curY;
        if (curX == XW'(IMG_W - 1)) begin
            xNext = '0;
            yNext = (curY == YW'(IMG_H - 1)) ? '0 : curY + 1'b1;
        end
    end

    // Combinational read gives old contents of the slot being overwritten this beat.
    assign line1Rd = line1Mem[curX];
    assign line2Rd = line2Mem[curX];

    always_ff @(posedge iCLK) begin
        if (bus.iDVAL) begin
            line1Mem[curX] <= bus.iGray;
            line2Mem[curX] <= line1Rd;
        end
    end

    assign colIn[0] = line2Rd;
    assign colIn[1] = line1Rd;
    assign colIn[2] = bus.iGray;

    // Row gi of the window: newest column comes straight from colIn, two older in registers.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            logic [DATA_W-1:0] tap0Reg, tap1Reg;
            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    tap0Reg <= '0;
                    tap1Reg <= '0;
                end else if (bus.iDVAL) begin
                    tap0Reg <= colIn[gi];
                    tap1Reg <= tap0Reg;
                end
            end
            assign win[gi][0] = tap1Reg;
            assign win[gi][1] = tap0Reg;
            assign win[gi][2] = colIn[gi];
        end
    endgenerate

    always_comb begin
        center   = win[1][1];
        gaussSum = '0;
        neighSum = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                gaussSum = gaussSum + (GW'(win[r][c]) << ((r == 1 ? 1 : 0) + (c == 1 ? 1 : 0)));
                if (!(r == 1 && c == 1))
                    neighSum = neighSum + NW'(win[r][c]);
            end
        end
        gaussOut = DATA_W'(gaussSum >> 4);
        lapVal   = $signed({2'b00, center, 3'b000}) - $signed({2'b00, neighSum});
        lapAbs   = lapVal[LW-1] ? LW'(-lapVal) : LW'(lapVal);
        lapSat   = (lapAbs > LW'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : DATA_W'(lapAbs);

        case (modeReg)
            2'd1:    modeResult = gaussOut;
            2'd2:    modeResult = lapSat;
            default: modeResult = center;
        endcase

        if (curX == '0 || curY == '0)
            pixelNext = '0;
        else if (curX == XW'(1) || curY == YW'(1))
            pixelNext = center;
        else
            pixelNext = modeResult;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            xReg     <= '0;
            yReg     <= '0;
            modeReg  <= 2'd1;
            pixelReg <= '0;
            dvalReg  <= 1'b0;
            eofReg   <= 1'b0;
        end else begin
            dvalReg <= bus.iDVAL;
            eofReg  <= bus.iDVAL & isLast;
            if (bus.iDVAL) begin
                xReg     <= xNext;
                yReg     <= yNext;
                pixelReg <= pixelNext;
                if (curX == '0 && curY == '0)
                    modeReg <= bus.iMode;
            end
        end
    end

    assign bus.oPixel = pixelReg;
    assign bus.oDVAL  = dvalReg;
    assign bus.oEOF   = eofReg;
endmodule

// File: tb/tb_gaussian_filter_param.sv
// Directed bench for gaussian_filter_param on an 8x6 frame with 12-bit pixels.
module tb_gaussian_filter_param;
    localparam int DW = 12;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gaussian_filter_param_if #(.DATA_W(DW)) bus ();

    gaussian_filter_param #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] outQ [$];
    bit            eofQ [$];
    int            img    [N];
    int            rnd    [N];
    int            refOut [N];

    typedef struct {
        int kind;   // 0 flat 100, 1 impulse 1600, 2 impulse 4095, 3 impulse 160
        int mode;
        int pos;    // input beat index y*W+x
        int exp;
    } vec_t;
    vec_t vecs [$];

    always @(negedge clk) begin
        if (bus.oDVAL) begin
            outQ.push_back(bus.oPixel);
            eofQ.push_back(bus.oEOF);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("check %s: got %0d ok", name, act);
        end
    endtask

    function automatic int getOut(input int i);
        return (i < outQ.size()) ? int'(outQ[i]) : -1;
    endfunction

    function automatic int eofCount();
        int c = 0;
        foreach (eofQ[i]) c += int'(eofQ[i]);
        return c;
    endfunction

    function automatic int eofAt(input int i);
        return (i < eofQ.size()) ? int'(eofQ[i]) : -1;
    endfunction

    task automatic buildImg(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       img[i] = 100;
                1:       img[i] = (i == 27) ? 1600 : 0;
                2:       img[i] = (i == 27) ? 4095 : 0;
                3:       img[i] = (i == 27) ? 160 : 0;
                default: img[i] = rnd[i];
            endcase
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.iDVAL = 1'b0;
        bus.iSOF  = 1'b0;
        bus.iGray = DW'($urandom_range(0, 4095));
    endtask

    // Drives one frame; iMode switches from mode0 to mode1 at beat switchAt.
    task automatic sendFrame(input int mode0, input int mode1, input int switchAt,
                             input bit gaps, input bit useSof);
        outQ.delete();
        eofQ.delete();
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) idle();
            end
            @(negedge clk);
            bus.iDVAL = 1'b1;
            bus.iSOF  = useSof && (i == 0);
            bus.iGray = DW'(img[i]);
            bus.iMode = 2'((i < switchAt) ? mode0 : mode1);
        end
        idle();
        idle();
    endtask

    initial begin
        rst       = 1'b1;
        bus.iDVAL = 1'b0;
        bus.iSOF  = 1'b0;
        bus.iGray = '0;
        bus.iMode = 2'd1;
        repeat (3) @(negedge clk);
        check("reset oDVAL", int'(bus.oDVAL), 0);
        check("reset oPixel", int'(bus.oPixel), 0);
        check("reset oEOF", int'(bus.oEOF), 0);
        rst = 1'b0;

        // Flat frame: borders 0 / raw center, interior Gaussian = 100, Laplacian = 0.
        vecs.push_back('{0, 1, 0, 0});    vecs.push_back('{0, 1, 5, 0});
        vecs.push_back('{0, 1, 8, 0});    vecs.push_back('{0, 1, 9, 100});
        vecs.push_back('{0, 1, 12, 100}); vecs.push_back('{0, 1, 17, 100});
        vecs.push_back('{0, 1, 18, 100}); vecs.push_back('{0, 1, 47, 100});
        vecs.push_back('{0, 2, 9, 100});  vecs.push_back('{0, 2, 16, 0});
        vecs.push_back('{0, 2, 18, 0});   vecs.push_back('{0, 2, 47, 0});
        // Impulse at (3,3): window center for beat (x,y) is (x-1,y-1).
        vecs.push_back('{1, 1, 36, 400}); vecs.push_back('{1, 1, 35, 200});
        vecs.push_back('{1, 1, 37, 200}); vecs.push_back('{1, 1, 28, 200});
        vecs.push_back('{1, 1, 44, 200}); vecs.push_back('{1, 1, 27, 100});
        vecs.push_back('{1, 1, 45, 100}); vecs.push_back('{1, 1, 29, 100});
        vecs.push_back('{1, 1, 20, 0});
        vecs.push_back('{3, 2, 36, 1280}); vecs.push_back('{3, 2, 35, 160});
        vecs.push_back('{3, 2, 28, 160});  vecs.push_back('{3, 2, 27, 160});
        vecs.push_back('{3, 2, 45, 160});
        vecs.push_back('{1, 2, 36, 4095}); vecs.push_back('{1, 2, 35, 1600});
        vecs.push_back('{2, 2, 36, 4095}); vecs.push_back('{2, 2, 37, 4095});
        vecs.push_back('{2, 2, 44, 4095}); vecs.push_back('{2, 2, 29, 4095});
        vecs.push_back('{2, 1, 36, 1023});
        vecs.push_back('{1, 3, 36, 1600}); vecs.push_back('{1, 3, 35, 0});
        vecs.push_back('{1, 0, 36, 1600});

        foreach (vecs[v]) begin
            buildImg(vecs[v].kind);
            sendFrame(vecs[v].mode, vecs[v].mode, N, 1'b0, 1'b1);
            check($sformatf("vec%0d beats", v), outQ.size(), N);
            check($sformatf("vec%0d k%0d m%0d p%0d", v, vecs[v].kind, vecs[v].mode, vecs[v].pos),
                  getOut(vecs[v].pos), vecs[v].exp);
        end

        // Gap-free reference run, then the same frame with random iDVAL gaps.
        for (int i = 0; i < N; i++) rnd[i] = int'($urandom_range(0, 4095));
        buildImg(4);
        sendFrame(1, 1, N, 1'b0, 1'b1);
        check("ref beats", outQ.size(), N);
        for (int i = 0; i < N; i++) refOut[i] = getOut(i);
        sendFrame(1, 1, N, 1'b1, 1'b1);
        check("gap beats", outQ.size(), N);
        for (int i = 0; i < N; i++) check($sformatf("gap beat%0d", i), getOut(i), refOut[i]);
        check("gap eof count", eofCount(), 1);
        check("gap eof last", eofAt(N - 1), 1);

        // Mid-frame iMode change is ignored; next SOF frame is bypass.
        sendFrame(1, 0, 20, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) check($sformatf("modehold beat%0d", i), getOut(i), refOut[i]);
        sendFrame(0, 0, N, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) begin
            if ((i % W) == 0 || (i / W) == 0)
                check($sformatf("bypass beat%0d", i), getOut(i), 0);
            else
                check($sformatf("bypass beat%0d", i), getOut(i), img[i - 9]);
        end

        // One-cycle reset mid-line, with iDVAL high on the reset cycle.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.iDVAL = 1'b1;
            bus.iSOF  = (i == 0);
            bus.iGray = DW'(img[i]);
            bus.iMode = 2'd1;
        end
        @(negedge clk);
        rst       = 1'b1;
        bus.iDVAL = 1'b1;
        bus.iSOF  = 1'b0;
        bus.iGray = DW'(123);
        @(negedge clk);
        rst       = 1'b0;
        bus.iDVAL = 1'b0;
        check("midreset oDVAL", int'(bus.oDVAL), 0);
        check("midreset oPixel", int'(bus.oPixel), 0);
        sendFrame(1, 1, N, 1'b0, 1'b0);
        check("postreset beats", outQ.size(), N);
        check("postreset first", getOut(0), 0);
        for (int i = 1; i < N; i++) check($sformatf("postreset beat%0d", i), getOut(i), refOut[i]);
        check("postreset eof count", eofCount(), 1);
        check("postreset eof last", eofAt(N - 1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
